// File: rtl/vend_ctrl.sv
// Vending-machine controller: collects coin credit, vends one affordable drink,
// then pays the remainder back one coin per change_ready handshake.
module vend_ctrl #(
   parameter int NUM_DRINKS = 4,
   parameter int CREDIT_W = 8,
   parameter int MAX_CREDIT = 100,
   parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10}
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          coin_valid,
   input  logic [1:0]                    coin_sel,
   input  logic                          sel_valid,
   input  logic [$clog2(NUM_DRINKS)-1:0] sel_id,
   input  logic                          cancel,
   input  logic                          change_ready,
   output logic [CREDIT_W-1:0]           credit,
   output logic [NUM_DRINKS-1:0]         avail,
   output logic                          drink_valid,
   output logic [$clog2(NUM_DRINKS)-1:0] drink_id,
   output logic                          change_valid,
   output logic [1:0]                    change_coin,
   output logic                          coin_reject,
   output logic                          sel_reject,
   output logic                          busy
);

   localparam int ID_W = $clog2(NUM_DRINKS);
   localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [ID_W:0] NUM_EXT = (ID_W+1)'(NUM_DRINKS);

   typedef enum logic [1:0] {
      COLLECT,
      VEND,
      CHANGE
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [ID_W-1:0]     drink_id_q, drink_id_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_reject_q, sel_reject_d;

   logic [CREDIT_W-1:0] price [NUM_DRINKS];
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] sel_price;
   logic [CREDIT_W-1:0] vend_price;
   logic                sel_ok;
   logic [1:0]          chg_code;
   logic [CREDIT_W-1:0] chg_val;

   genvar g;
   generate
      for (g = 0; g < NUM_DRINKS; g++) begin : g_price
         assign price[g] = PRICE_LIST[g*CREDIT_W +: CREDIT_W];
      end
   endgenerate

   always_comb begin
      coin_val = CREDIT_W'(1);
      case (coin_sel)
         2'd0:    coin_val = CREDIT_W'(1);
         2'd1:    coin_val = CREDIT_W'(5);
         2'd2:    coin_val = CREDIT_W'(10);
         default: coin_val = CREDIT_W'(50);
      endcase
   end

   // Ceiling check is one bit wider than credit so the sum can never wrap.
   assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_fits = (coin_sum <= MAX_EXT);

   always_comb begin
      sel_price  = '0;
      vend_price = '0;
      for (int i = 0; i < NUM_DRINKS; i++) begin
         if (ID_W'(i) == sel_id)     sel_price  = price[i];
         if (ID_W'(i) == drink_id_q) vend_price = price[i];
      end
   end

   assign sel_ok = ({1'b0, sel_id} < NUM_EXT) && (sel_price <= credit_q);

   // Greedy change: always offer the largest coin that still fits the credit.
   always_comb begin
      chg_code = 2'd0;
      chg_val  = CREDIT_W'(1);
      if (credit_q >= CREDIT_W'(50)) begin
         chg_code = 2'd3;
         chg_val  = CREDIT_W'(50);
      end else if (credit_q >= CREDIT_W'(10)) begin
         chg_code = 2'd2;
         chg_val  = CREDIT_W'(10);
      end else if (credit_q >= CREDIT_W'(5)) begin
         chg_code = 2'd1;
         chg_val  = CREDIT_W'(5);
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      drink_id_d    = drink_id_q;
      coin_reject_d = 1'b0;
      sel_reject_d  = 1'b0;
      case (state_q)
         COLLECT: begin
            if (cancel && (credit_q != '0)) begin
               state_d       = CHANGE;
               coin_reject_d = coin_valid;
            end else if (sel_valid && sel_ok) begin
               state_d       = VEND;
               drink_id_d    = sel_id;
               coin_reject_d = coin_valid;
            end else begin
               sel_reject_d = sel_valid;
               if (coin_valid) begin
                  if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
                  else           coin_reject_d = 1'b1;
               end
            end
         end
         VEND: begin
            coin_reject_d = coin_valid;
            credit_d      = credit_q - vend_price;
            state_d       = (credit_d != '0) ? CHANGE : COLLECT;
         end
         CHANGE: begin
            coin_reject_d = coin_valid;
            if (change_ready) begin
               credit_d = credit_q - chg_val;
               if (credit_d == '0) state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= COLLECT;
         credit_q      <= '0;
         drink_id_q    <= '0;
         coin_reject_q <= 1'b0;
         sel_reject_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         drink_id_q    <= drink_id_d;
         coin_reject_q <= coin_reject_d;
         sel_reject_q  <= sel_reject_d;
      end
   end

   always_comb begin
      avail = '0;
      for (int i = 0; i < NUM_DRINKS; i++)
         avail[i] = (state_q == COLLECT) && (credit_q >= price[i]);
   end

   assign credit       = credit_q;
   assign drink_valid  = (state_q == VEND);
   assign drink_id     = drink_id_q;
   assign change_valid = (state_q == CHANGE);
   assign change_coin  = chg_code;
   assign coin_reject  = coin_reject_q;
   assign sel_reject   = sel_reject_q;
   assign busy         = (state_q != COLLECT);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: table vectors, hand-written corner sequences
// and randomized traffic compared against a behavioural model of the machine.
module tb_vend_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_sel;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       cancel;
   logic       change_ready;
   logic [7:0] credit;
   logic [3:0] avail;
   logic       drink_valid;
   logic [1:0] drink_id;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       coin_reject;
   logic       sel_reject;
   logic       busy;

   int errors = 0;
   int checks = 0;

   int price [4] = '{10, 15, 20, 25};
   int denom [4] = '{1, 5, 10, 50};

   // Model: phase 0 = collecting, 1 = vending, 2 = paying change
   int m_credit, m_phase, m_drink;
   bit m_crej, m_srej;

   vend_ctrl dut (
      .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
      .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
      .change_ready(change_ready), .credit(credit), .avail(avail),
      .drink_valid(drink_valid), .drink_id(drink_id), .change_valid(change_valid),
      .change_coin(change_coin), .coin_reject(coin_reject), .sel_reject(sel_reject),
      .busy(busy)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int largest(input int c);
      for (int i = 3; i >= 0; i--)
         if (denom[i] <= c) return i;
      return 0;
   endfunction

   task automatic model_step();
      bit cr, sr;
      cr = 0;
      sr = 0;
      if (reset) begin
         m_credit = 0; m_phase = 0; m_drink = 0; m_crej = 0; m_srej = 0;
         return;
      end
      case (m_phase)
         0: begin
            if (cancel && m_credit > 0) begin
               m_phase = 2;
               cr = coin_valid;
            end else if (sel_valid && int'(sel_id) < 4 && price[sel_id] <= m_credit) begin
               m_drink = int'(sel_id);
               m_phase = 1;
               cr = coin_valid;
            end else begin
               sr = sel_valid;
               if (coin_valid) begin
                  if (m_credit + denom[coin_sel] <= 100) m_credit += denom[coin_sel];
                  else cr = 1;
               end
            end
         end
         1: begin
            m_credit -= price[m_drink];
            m_phase = (m_credit > 0) ? 2 : 0;
            cr = coin_valid;
         end
         default: begin
            cr = coin_valid;
            if (change_ready) begin
               m_credit -= denom[largest(m_credit)];
               if (m_credit == 0) m_phase = 0;
            end
         end
      endcase
      m_crej = cr;
      m_srej = sr;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit cv, input bit [1:0] cs, input bit sv,
                                input bit [1:0] sid, input bit can, input bit rdy);
      coin_valid   = cv;
      coin_sel     = cs;
      sel_valid    = sv;
      sel_id       = sid;
      cancel       = can;
      change_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input bit rdy);
      applyStimulus(0, 2'd0, 0, 2'd0, 0, rdy);
   endtask

   task automatic coin(input bit [1:0] cs);
      applyStimulus(1, cs, 0, 2'd0, 0, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      idle(0);
      reset = 1'b0;
   endtask

   task automatic compareModel(input string tag);
      int ea;
      ea = 0;
      for (int i = 0; i < 4; i++)
         if (m_phase == 0 && m_credit >= price[i]) ea |= (1 << i);
      checkOutput({tag, ".credit"}, int'(credit), m_credit);
      checkOutput({tag, ".avail"}, int'(avail), ea);
      checkOutput({tag, ".drink_valid"}, int'(drink_valid), int'(m_phase == 1));
      checkOutput({tag, ".change_valid"}, int'(change_valid), int'(m_phase == 2));
      checkOutput({tag, ".coin_reject"}, int'(coin_reject), int'(m_crej));
      checkOutput({tag, ".sel_reject"}, int'(sel_reject), int'(m_srej));
      checkOutput({tag, ".busy"}, int'(busy), int'(m_phase != 0));
      if (m_phase == 1) checkOutput({tag, ".drink_id"}, int'(drink_id), m_drink);
      if (m_phase == 2) checkOutput({tag, ".change_coin"}, int'(change_coin), largest(m_credit));
   endtask

   typedef struct {
      bit       cv;
      bit [1:0] cs;
      bit       sv;
      bit [1:0] sid;
      bit       can;
      bit       rdy;
      int       e_credit;
      int       e_avail;
      bit       e_dv;
      bit       e_chv;
      bit       e_crej;
      bit       e_srej;
      bit       e_busy;
   } vec_t;

   function automatic vec_t mk(input bit cv, input bit [1:0] cs, input bit sv,
                               input bit [1:0] sid, input bit can, input bit rdy,
                               input int ec, input int ea, input bit edv, input bit echv,
                               input bit ecr, input bit esr, input bit eb);
      vec_t v;
      v.cv = cv; v.cs = cs; v.sv = sv; v.sid = sid; v.can = can; v.rdy = rdy;
      v.e_credit = ec; v.e_avail = ea; v.e_dv = edv; v.e_chv = echv;
      v.e_crej = ecr; v.e_srej = esr; v.e_busy = eb;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      int   n;

      reset = 1'b0;
      coin_valid = 0; coin_sel = 0; sel_valid = 0; sel_id = 0; cancel = 0; change_ready = 0;

      vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 0, 10, 4'b0001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'd1, 0, 2'd0, 0, 0, 15, 4'b0011, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 1, 2'd1, 0, 0, 15, 4'b0000, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 1,  0, 4'b0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 0, 10, 4'b0001, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'd2, 0, 2'd0, 0, 0, 20, 4'b0111, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 1, 2'd3, 0, 0, 20, 4'b0111, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 0, 20, 4'b0111, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 1, 0, 20, 4'b0000, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 1, 10, 4'b0000, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 0, 2'd0, 0, 1,  0, 4'b0000, 0, 0, 0, 0, 0));

      // Reset state
      doReset();
      checkOutput("rst.credit", int'(credit), 0);
      checkOutput("rst.avail", int'(avail), 0);
      checkOutput("rst.drink_valid", int'(drink_valid), 0);
      checkOutput("rst.drink_id", int'(drink_id), 0);
      checkOutput("rst.change_valid", int'(change_valid), 0);
      checkOutput("rst.coin_reject", int'(coin_reject), 0);
      checkOutput("rst.sel_reject", int'(sel_reject), 0);
      checkOutput("rst.busy", int'(busy), 0);

      // Table vectors
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].cv, vecs[i].cs, vecs[i].sv, vecs[i].sid, vecs[i].can, vecs[i].rdy);
         checkOutput($sformatf("vec%0d.credit", i), int'(credit), vecs[i].e_credit);
         checkOutput($sformatf("vec%0d.avail", i), int'(avail), vecs[i].e_avail);
         checkOutput($sformatf("vec%0d.drink_valid", i), int'(drink_valid), int'(vecs[i].e_dv));
         checkOutput($sformatf("vec%0d.change_valid", i), int'(change_valid), int'(vecs[i].e_chv));
         checkOutput($sformatf("vec%0d.coin_reject", i), int'(coin_reject), int'(vecs[i].e_crej));
         checkOutput($sformatf("vec%0d.sel_reject", i), int'(sel_reject), int'(vecs[i].e_srej));
         checkOutput($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
         if (vecs[i].e_dv) checkOutput($sformatf("vec%0d.drink_id", i), int'(drink_id), 1);
      end

      // Coin 50, buy drink 0, change 4x10 with a 3-cycle stall
      doReset();
      coin(2'd3);
      applyStimulus(0, 2'd0, 1, 2'd0, 0, 0);
      checkOutput("seqA.drink_valid", int'(drink_valid), 1);
      checkOutput("seqA.drink_id", int'(drink_id), 0);
      idle(0);
      checkOutput("seqA.credit40", int'(credit), 40);
      checkOutput("seqA.coin10", int'(change_coin), 2);
      idle(1);
      checkOutput("seqA.credit30", int'(credit), 30);
      for (int i = 0; i < 3; i++) begin
         idle(0);
         checkOutput("seqA.stall_credit", int'(credit), 30);
         checkOutput("seqA.stall_valid", int'(change_valid), 1);
         checkOutput("seqA.stall_coin", int'(change_coin), 2);
      end
      idle(1);
      idle(1);
      idle(1);
      checkOutput("seqA.final_credit", int'(credit), 0);
      checkOutput("seqA.final_busy", int'(busy), 0);
      compareModel("seqA");

      // Ceiling: 99 then 5 rejected, 1 accepted to 100, coin during VEND rejected
      doReset();
      coin(2'd3); coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd2);
      coin(2'd1); coin(2'd0); coin(2'd0); coin(2'd0); coin(2'd0);
      checkOutput("seqB.credit99", int'(credit), 99);
      coin(2'd1);
      checkOutput("seqB.reject5", int'(coin_reject), 1);
      checkOutput("seqB.still99", int'(credit), 99);
      coin(2'd0);
      checkOutput("seqB.credit100", int'(credit), 100);
      checkOutput("seqB.accept1", int'(coin_reject), 0);
      applyStimulus(0, 2'd0, 1, 2'd3, 0, 0);
      checkOutput("seqB.vend", int'(drink_valid), 1);
      applyStimulus(1, 2'd0, 0, 2'd0, 0, 0);
      checkOutput("seqB.vend_coin_reject", int'(coin_reject), 1);
      checkOutput("seqB.credit75", int'(credit), 75);
      n = 0;
      while (busy && n < 20) begin
         idle(1);
         n++;
      end
      checkOutput("seqB.drain_cycles", n, 4);
      checkOutput("seqB.drained", int'(credit), 0);

      // Cancel + select + coin together: cancel wins, change 10,5,1
      doReset();
      coin(2'd2); coin(2'd1); coin(2'd0);
      checkOutput("seqC.credit16", int'(credit), 16);
      applyStimulus(1, 2'd0, 1, 2'd0, 1, 0);
      checkOutput("seqC.change_valid", int'(change_valid), 1);
      checkOutput("seqC.coin_reject", int'(coin_reject), 1);
      checkOutput("seqC.drink_valid", int'(drink_valid), 0);
      checkOutput("seqC.coin10", int'(change_coin), 2);
      idle(1);
      checkOutput("seqC.coin5", int'(change_coin), 1);
      idle(1);
      checkOutput("seqC.coin1", int'(change_coin), 0);
      idle(1);
      checkOutput("seqC.credit0", int'(credit), 0);
      checkOutput("seqC.busy", int'(busy), 0);

      // Reset during CHANGE with 40 pending
      doReset();
      coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd2);
      applyStimulus(0, 2'd0, 0, 2'd0, 1, 0);
      checkOutput("seqD.in_change", int'(change_valid), 1);
      checkOutput("seqD.credit40", int'(credit), 40);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      checkOutput("seqD.credit", int'(credit), 0);
      checkOutput("seqD.change_valid", int'(change_valid), 0);
      checkOutput("seqD.busy", int'(busy), 0);
      idle(1);
      compareModel("seqD.after");

      // Randomized traffic against the model
      doReset();
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
         reset = 1'b0;
         compareModel($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
